// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, read-first, registered read data, no reset.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write when enabled; the addressed word is always registered out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR datapath: captures one request,
// waits WAIT_STATES cycles, accesses the array and pulses Done.
// Optional bounds/conflict checking with an Err output: MEM_BOUNDS_CHECK_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_STATES = 1
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    parameter int unsigned LIMIT       = (2**ADDR_W) - 1
`endif
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] MDR_in,
    output logic [DATA_W-1:0] MDatain,
    output logic              Done,
    output logic              Busy
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic              Err
`endif
);

    localparam bit              HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [CNT_W-1:0] CNT_INIT = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    op_e                 op_q;
    logic                bad_q;
    logic [DATA_W-1:0]   ram_dout;

    logic                capture_c;
    logic                cnt_dec_c;
    logic                ram_we_c;
    logic                rd_load_c;
    logic                done_c;

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (Read || Write) state_nxt = HAS_WAIT ? ST_WAIT : ST_ACCESS;
            ST_WAIT:    if (cnt == '0) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_RELEASE;
            ST_RELEASE: if (!Read && !Write) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes; a flagged request keeps its timing but never touches the array.
    always_comb begin
        capture_c = 1'b0;
        cnt_dec_c = 1'b0;
        ram_we_c  = 1'b0;
        rd_load_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE:   capture_c = Read || Write;
            ST_WAIT:   cnt_dec_c = (cnt != '0);
            ST_ACCESS: ram_we_c  = (op_q == OP_WRITE) && !bad_q;
            ST_DONE: begin
                done_c    = 1'b1;
                rd_load_c = (op_q == OP_READ) && !bad_q;
            end
            default: ;
        endcase
    end

    // Request latches and wait counter; inputs are ignored outside IDLE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q <= '0;
            data_q <= '0;
            op_q   <= OP_READ;
            cnt    <= '0;
        end else if (capture_c) begin
            addr_q <= address;
            data_q <= MDR_in;
            op_q   <= Read ? OP_READ : OP_WRITE;
            cnt    <= CNT_INIT;
        end else if (cnt_dec_c) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // Flag out-of-range addresses and conflicting Read/Write at capture.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bad_q <= 1'b0;
        end else if (capture_c) begin
            bad_q <= (32'(address) > LIMIT) || (Read && Write);
        end
    end

    // Err accompanies the Done pulse of a flagged request.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Err <= 1'b0;
        end else begin
            Err <= done_c && bad_q;
        end
    end
`else
    assign bad_q = 1'b0;
`endif

    // Registered outputs; read data arrives from the RAM one cycle after ACCESS.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            MDatain <= '0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            Done <= done_c;
            Busy <= (state_nxt != ST_IDLE);
            if (rd_load_c) begin
                MDatain <= ram_dout;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (ram_we_c),
        .addr (addr_q),
        .din  (data_q),
        .dout (ram_dout)
    );

endmodule
